// File: rtl/alu_seq.sv
// Registered single-cycle ALU plus an iterative unsigned multiply/divide unit
// (shift-add MUL, restoring DIV, one bit per clock) behind a Start/Busy/Done handshake.
module alu_seq #(
   parameter  int N  = 32,
   localparam int CW = $clog2(N) + 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         Start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [3:0]   F,
   output logic [N-1:0] Y,
   output logic         Ovf,
   output logic         Zero,
   output logic         DivZero,
   output logic         Busy,
   output logic         Done
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t         r_state, w_state_nxt;
   logic [N-1:0]   r_acc, r_q, r_div, r_y;
   logic [N-1:0]   w_acc_nxt, w_q_nxt, w_div_nxt, w_y_nxt;
   logic [1:0]     r_f, w_f_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic           r_ovf, r_dz, r_done;
   logic           w_ovf_nxt, w_dz_nxt, w_done_nxt;

   // Single-cycle path
   logic [N-1:0]   w_bout, w_sum, w_alu;
   logic           w_v;

   assign w_bout = F[2] ? ~B : B;
   assign w_sum  = A + w_bout + {{(N-1){1'b0}}, F[2]};
   assign w_v    = (A[N-1] == w_bout[N-1]) & (w_sum[N-1] != A[N-1]);

   always_comb begin
      w_alu = '0;
      case (F[1:0])
         2'b00: w_alu = A & w_bout;
         2'b01: w_alu = A | w_bout;
         2'b10: w_alu = w_sum;
         2'b11: w_alu = {{(N-1){1'b0}}, w_sum[N-1] ^ w_v};
         default: w_alu = '0;
      endcase
   end

   // One iteration step; low half / quotient lives in r_q, high half / remainder in r_acc
   logic [N:0]     w_madd, w_shift, w_diff;
   logic           w_ge, w_last;
   logic [N-1:0]   w_it_acc, w_it_q;

   assign w_madd  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_div} : '0);
   assign w_shift = {r_acc, r_q[N-1]};
   assign w_ge    = (w_shift >= {1'b0, r_div});
   assign w_diff  = w_shift - {1'b0, r_div};
   assign w_last  = (r_cnt == CW'(N-1));

   always_comb begin
      if (r_state == S_DIV) begin
         w_it_acc = w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
         w_it_q   = {r_q[N-2:0], w_ge};
      end else begin
         w_it_acc = w_madd[N:1];
         w_it_q   = {w_madd[0], r_q[N-1:1]};
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_acc_nxt   = r_acc;
      w_q_nxt     = r_q;
      w_div_nxt   = r_div;
      w_f_nxt     = r_f;
      w_cnt_nxt   = r_cnt;
      w_y_nxt     = r_y;
      w_ovf_nxt   = r_ovf;
      w_dz_nxt    = r_dz;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (Start) begin
               if (!F[3]) begin
                  w_y_nxt    = w_alu;
                  w_ovf_nxt  = (F[1:0] == 2'b10) & w_v;
                  w_dz_nxt   = 1'b0;
                  w_done_nxt = 1'b1;
               end else if (F[1] && (B == '0)) begin
                  w_y_nxt    = F[0] ? A : '1;
                  w_ovf_nxt  = 1'b0;
                  w_dz_nxt   = 1'b1;
                  w_done_nxt = 1'b1;
               end else begin
                  w_acc_nxt   = '0;
                  w_q_nxt     = A;
                  w_div_nxt   = B;
                  w_f_nxt     = F[1:0];
                  w_cnt_nxt   = '0;
                  w_state_nxt = F[1] ? S_DIV : S_MUL;
               end
            end
         end
         S_MUL, S_DIV: begin
            w_acc_nxt = w_it_acc;
            w_q_nxt   = w_it_q;
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_last) begin
               w_state_nxt = S_IDLE;
               w_y_nxt     = r_f[0] ? w_it_acc : w_it_q;
               w_ovf_nxt   = (r_state == S_MUL) && (r_f == 2'b00) && (|w_it_acc);
               w_dz_nxt    = 1'b0;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_q     <= '0;
         r_div   <= '0;
         r_f     <= '0;
         r_cnt   <= '0;
         r_y     <= '0;
         r_ovf   <= 1'b0;
         r_dz    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_acc   <= w_acc_nxt;
         r_q     <= w_q_nxt;
         r_div   <= w_div_nxt;
         r_f     <= w_f_nxt;
         r_cnt   <= w_cnt_nxt;
         r_y     <= w_y_nxt;
         r_ovf   <= w_ovf_nxt;
         r_dz    <= w_dz_nxt;
         r_done  <= w_done_nxt;
      end
   end

   assign Y       = r_y;
   assign Ovf     = r_ovf;
   assign DivZero = r_dz;
   assign Done    = r_done;
   assign Busy    = (r_state != S_IDLE);
   assign Zero    = (r_y == '0);

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, random ops against an
// arithmetic reference model, handshake and reset-abort checks, plus an N=8 instance.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        Start, Start8;
   logic [31:0] A, B, Y;
   logic [7:0]  A8, B8, Y8;
   logic [3:0]  F, F8;
   logic        Ovf, Zero, DivZero, Busy, Done;
   logic        Ovf8, Zero8, DivZero8, Busy8, Done8;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_seq #(.N(32)) u_dut (
      .clk(clk), .reset_n(reset_n), .Start(Start), .A(A), .B(B), .F(F),
      .Y(Y), .Ovf(Ovf), .Zero(Zero), .DivZero(DivZero), .Busy(Busy), .Done(Done)
   );

   alu_seq #(.N(8)) u_dut8 (
      .clk(clk), .reset_n(reset_n), .Start(Start8), .A(A8), .B(B8), .F(F8),
      .Y(Y8), .Ovf(Ovf8), .Zero(Zero8), .DivZero(DivZero8), .Busy(Busy8), .Done(Done8)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      else n_pass++;
   endtask

   // Reference: operands taken as n-bit unsigned/signed integers, evaluated exactly in 64 bits
   function automatic void ref_model(input int n, input logic [31:0] a, input logic [31:0] b,
                                     input logic [3:0] f, output logic [31:0] y,
                                     output logic ovf, output logic dz);
      longint unsigned mask, ua, ub, bo, p, r;
      longint sa, sb, s, lim;
      mask = (64'd1 << n) - 1;
      ua = a & mask;
      ub = b & mask;
      bo = f[2] ? (~ub & mask) : ub;
      lim = longint'(64'd1 << (n-1));
      sa = longint'(ua) - ((ua >= longint'(lim)) ? 2*lim : 0);
      sb = longint'(bo) - ((bo >= longint'(lim)) ? 2*lim : 0);
      s  = sa + sb + longint'(f[2]);
      ovf = 1'b0;
      dz  = 1'b0;
      r   = 0;
      if (!f[3]) begin
         case (f[1:0])
            2'b00: r = ua & bo;
            2'b01: r = ua | bo;
            2'b10: begin r = longint'(s) & mask; ovf = (s >= lim) || (s < -lim); end
            default: r = (s < 0) ? 1 : 0;
         endcase
      end else if (!f[1]) begin
         p   = ua * ub;
         r   = f[0] ? (p >> n) : p;
         ovf = !f[0] && ((p >> n) != 0);
      end else if (ub == 0) begin
         r  = f[0] ? ua : mask;
         dz = 1'b1;
      end else begin
         r = f[0] ? (ua % ub) : (ua / ub);
      end
      y = 32'(r & mask);
   endfunction

   function automatic int exp_lat(input int n, input logic [31:0] b, input logic [3:0] f);
      return (f[3] && !(f[1] && b == 0)) ? n + 1 : 1;
   endfunction

   // Waits for Done with a bound; optionally pokes ignored Start/operands while busy
   task automatic wait_done(input bit poke, inout int e);
      while (!Done && e < 100) begin
         @(posedge clk); #1;
         e++;
         if (poke && e == 5) begin
            Start = 1'b1; A = $urandom; B = $urandom; F = 4'($urandom);
         end
         if (poke && e == 6) Start = 1'b0;
      end
   endtask

   task automatic check_res(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] f, input int e);
      logic [31:0] y;
      logic ovf, dz;
      ref_model(32, a, b, f, y, ovf, dz);
      chk({tag, "_done"}, Done, 1'b1);
      chk({tag, "_lat"}, e, exp_lat(32, b, f));
      chk({tag, "_busy"}, Busy, 1'b0);
      chk({tag, "_y"}, Y, y);
      chk({tag, "_ovf"}, Ovf, ovf);
      chk({tag, "_dz"}, DivZero, dz);
      chk({tag, "_zero"}, Zero, y == 0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input bit poke);
      int e;
      logic [31:0] y;
      logic ovf, dz;
      @(negedge clk);
      A = a; B = b; F = f; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      e = 1;
      if (!Done) begin
         chk({tag, "_busy_acc"}, Busy, 1'b1);
         A = $urandom; B = $urandom; F = 4'($urandom);
      end
      wait_done(poke, e);
      check_res(tag, a, b, f, e);
      ref_model(32, a, b, f, y, ovf, dz);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, Done, 1'b0);
      chk({tag, "_hold"}, Y, y);
   endtask

   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] f);
      int e;
      logic [31:0] y;
      logic ovf, dz;
      ref_model(8, {24'd0, a}, {24'd0, b}, f, y, ovf, dz);
      @(negedge clk);
      A8 = a; B8 = b; F8 = f; Start8 = 1'b1;
      @(posedge clk); #1;
      Start8 = 1'b0;
      e = 1;
      while (!Done8 && e < 100) begin @(posedge clk); #1; e++; end
      chk({tag, "_lat"}, e, exp_lat(8, {24'd0, b}, f));
      chk({tag, "_y"}, Y8, y[7:0]);
      chk({tag, "_ovf"}, Ovf8, ovf);
   endtask

   initial begin
      int e, nd;
      reset_n = 1'b0;
      Start = 1'b0; A = '0; B = '0; F = '0;
      Start8 = 1'b0; A8 = '0; B8 = '0; F8 = '0;
      #3;
      chk("rst_y", Y, 32'd0);
      chk("rst_flags", {Ovf, DivZero, Busy, Done}, 4'b0000);
      chk("rst_zero", Zero, 1'b1);
      @(negedge clk); reset_n = 1'b1;

      run_op("add_ovf", 32'h7FFF_FFFF, 32'd1, 4'b0010, 1'b0);
      run_op("sub_zero", 32'd5, 32'd5, 4'b0110, 1'b0);
      run_op("slt_neg", 32'hFFFF_FFFF, 32'd1, 4'b0111, 1'b0);
      run_op("slt_min", 32'h8000_0000, 32'd1, 4'b0111, 1'b0);
      run_op("and", 32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 1'b0);
      run_op("orn", 32'h1200_0000, 32'h0000_FFFF, 4'b0101, 1'b0);
      run_op("mul_lo", 32'h0001_0000, 32'h0001_0000, 4'b1000, 1'b0);
      run_op("mul_hi", 32'h0001_0000, 32'h0001_0000, 4'b1001, 1'b0);
      run_op("mul_small", 32'd7, 32'd6, 4'b1000, 1'b1);
      run_op("divu", 32'd100, 32'd7, 4'b1010, 1'b1);
      run_op("remu", 32'd100, 32'd7, 4'b1011, 1'b0);
      run_op("div0", 32'd5, 32'd0, 4'b1010, 1'b0);
      run_op("rem0", 32'd5, 32'd0, 4'b1111, 1'b0);
      run_op("divbig", 32'hFFFF_FFFF, 32'h8000_0001, 4'b1110, 1'b0);

      // Start held high through Done: second op accepted in the Done cycle
      @(negedge clk);
      A = 32'd7; B = 32'd6; F = 4'b1000; Start = 1'b1;
      @(posedge clk); #1;
      e = 1;
      A = 32'd100; B = 32'd7; F = 4'b1010;
      wait_done(1'b0, e);
      check_res("b2b_a", 32'd7, 32'd6, 4'b1000, e);
      @(posedge clk); #1;
      Start = 1'b0;
      e = 1;
      chk("b2b_accept", Busy, 1'b1);
      wait_done(1'b0, e);
      check_res("b2b_b", 32'd100, 32'd7, 4'b1010, e);

      for (int i = 0; i < 40; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) begin ra = ra >> 20; rb = rb >> 24; end
         run_op("rnd", ra, rb, 4'($urandom), 1'($urandom));
      end

      // Reset at iteration 10 aborts the op with no Done
      run_op("pre_rst", 32'd3, 32'd4, 4'b0010, 1'b0);
      @(negedge clk);
      A = 32'h0001_0000; B = 32'h0001_0000; F = 4'b1001; Start = 1'b1;
      @(posedge clk); #1;
      Start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("abort_y", Y, 32'd0);
      chk("abort_flags", {Ovf, DivZero, Busy, Done}, 4'b0000);
      chk("abort_zero", Zero, 1'b1);
      @(negedge clk); reset_n = 1'b1;
      nd = 0;
      repeat (40) begin @(posedge clk); #1; if (Done) nd++; end
      chk("abort_nodone", nd, 0);
      chk("abort_y_hold", Y, 32'd0);

      run8("n8_mul_lo", 8'd255, 8'd255, 4'b1000);
      run8("n8_mul_hi", 8'd255, 8'd255, 4'b1001);
      run8("n8_div", 8'd200, 8'd9, 4'b1010);
      run8("n8_add", 8'h7F, 8'h01, 4'b0010);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
